// File: rtl/logic_op_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encoding and
// the result-parity helper used by the combinational ALU.
package logic_op_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOT  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  // Callers zero-extend narrower results; the extra zero bits leave the parity unchanged.
  function automatic logic parity_fn(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/logic_op_pipe_gate_alu.sv
// Purely combinational bitwise operation and result flags for logic_op_pipe.
module gate_alu
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  // Select the operation and derive flags from that same result.
  always_comb begin
    y = {WIDTH{1'b0}};
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_PASS: y = a;
      default: y = a;
    endcase
    zero   = (y == {WIDTH{1'b0}});
    ones   = (y == {WIDTH{1'b1}});
    parity = parity_fn(64'(y));
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready pipeline around gate_alu: S1 holds operands, S2 holds
// the registered result and flags, with a wrapping count of delivered results.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_ones,
  output logic             y_parity,
  output logic [CNT_W-1:0] done_count
);

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [OP_W-1:0]  s1_op_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] y_r;
  logic             zero_r;
  logic             ones_r;
  logic             parity_r;
  logic [CNT_W-1:0] cnt_r;

  logic             s2_load_s;
  logic             s1_load_s;
  logic [WIDTH-1:0] alu_y_s;
  logic             alu_zero_s;
  logic             alu_ones_s;
  logic             alu_parity_s;

  // in_ready depends on out_ready only, never on in_valid.
  assign s2_load_s = !s2_valid_r || out_ready;
  assign s1_load_s = !s1_valid_r || s2_load_s;
  assign in_ready  = s1_load_s;

  assign out_valid  = s2_valid_r;
  assign y          = y_r;
  assign y_zero     = zero_r;
  assign y_ones     = ones_r;
  assign y_parity   = parity_r;
  assign done_count = cnt_r;

  gate_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (s1_op_r),
    .a      (s1_a_r),
    .b      (s1_b_r),
    .y      (alu_y_s),
    .zero   (alu_zero_s),
    .ones   (alu_ones_s),
    .parity (alu_parity_s)
  );

  // Stage 1: capture operands on an input transfer; a load with no input leaves a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_op_r    <= {OP_W{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r  <= a;
        s1_b_r  <= b;
        s1_op_r <= op;
      end
    end
  end

  // Stage 2: register result and flags; data holds across bubbles and stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      y_r        <= {WIDTH{1'b0}};
      zero_r     <= 1'b0;
      ones_r     <= 1'b0;
      parity_r   <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        y_r      <= alu_y_s;
        zero_r   <= alu_zero_s;
        ones_r   <= alu_ones_s;
        parity_r <= alu_parity_s;
      end
    end
  end

  // Count results accepted downstream, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (s2_valid_r && out_ready) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed and randomised checks of logic_op_pipe (WIDTH=8, CNT_W=4) against hand values and a reference model.
module tb_logic_op_pipe;

  typedef struct {
    logic [7:0] y;
    logic       z;
    logic       o;
    logic       p;
    int         cyc;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       y_zero;
  logic       y_ones;
  logic       y_parity;
  logic [3:0] done_count;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];

  logic_op_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_zero(y_zero), .y_ones(y_ones), .y_parity(y_parity),
    .done_count(done_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ref_y(input logic [2:0] o, input logic [7:0] x, input logic [7:0] w);
    case (o)
      3'd0: return x & w;
      3'd1: return x | w;
      3'd2: return ~(x & w);
      3'd3: return ~(x | w);
      3'd4: return x ^ w;
      3'd5: return ~(x ^ w);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  // Record accepted inputs (with model result) and delivered outputs ahead of the next edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid && in_ready) begin
        beat_t e;
        e.y = ref_y(op, a, b);
        e.z = (e.y == 8'h00);
        e.o = (e.y == 8'hFF);
        e.p = ^e.y;
        e.cyc = cyc;
        exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        beat_t r;
        r.y = y; r.z = y_zero; r.o = y_ones; r.p = y_parity; r.cyc = cyc;
        obs_q.push_back(r);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; holds the beat until it is accepted.
  task automatic send(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
    bit acc = 1'b0;
    op = o; a = av; b = bv; in_valid = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < 600 && obs_q.size() < n; i++) @(negedge clk);
    check("drain_count", 64'(obs_q.size()), 64'(n));
    @(posedge clk);
    #1;
  endtask

  // Compare next delivered beat with the model; lat < 0 skips the latency check.
  task automatic cmp_model(input string tag, input int lat);
    beat_t e, r;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      check({tag, "_missing"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      r = obs_q.pop_front();
      check({tag, "_y"}, 64'(r.y), 64'(e.y));
      check({tag, "_flags"}, 64'({r.z, r.o, r.p}), 64'({e.z, e.o, e.p}));
      if (lat >= 0) check({tag, "_lat"}, 64'(r.cyc - e.cyc), 64'(lat));
    end
  endtask

  task automatic cmp_const(input string tag, input logic [7:0] ey, input logic [2:0] ef);
    beat_t r;
    if (obs_q.size() == 0) begin
      check({tag, "_missing"}, 64'd0, 64'd1);
    end else begin
      r = obs_q.pop_front();
      void'(exp_q.pop_front());
      check({tag, "_y"}, 64'(r.y), 64'(ey));
      check({tag, "_zop"}, 64'({r.z, r.o, r.p}), 64'(ef));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] sweep_y [8];
    sweep_y = '{8'h81, 8'hE7, 8'h7E, 8'h18, 8'h66, 8'h99, 8'h3C, 8'hC3};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = 8'h00; b = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_flags", 64'({y_zero, y_ones, y_parity}), 64'd0);
    check("rst_done", 64'(done_count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Ops sweep with hand values and 2-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(3'(i), 8'hC3, 8'hA5);
    drain(8);
    for (int i = 0; i < 8; i++) begin
      check("sweep_lat", 64'(obs_q[0].cyc - exp_q[0].cyc), 64'd2);
      cmp_const($sformatf("sweep_op%0d", i), sweep_y[i], {sweep_y[i] == 8'h00, sweep_y[i] == 8'hFF, ^sweep_y[i]});
    end

    // Flag corner cases
    send(3'd2, 8'hFF, 8'hFF);
    send(3'd3, 8'h00, 8'h00);
    send(3'd4, 8'h01, 8'h00);
    drain(3);
    cmp_const("flag_nand", 8'h00, 3'b100);
    cmp_const("flag_nor", 8'hFF, 3'b010);
    cmp_const("flag_xor", 8'h01, 3'b001);
    check("done_after_11", 64'(done_count), 64'd11);

    // Backpressure: two accepted, stable stall, ordered release
    do_reset();
    out_ready = 1'b0;
    send(3'd0, 8'hF0, 8'h3C);
    send(3'd1, 8'hF0, 8'h0F);
    op = 3'd4; a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_y_stable", 64'({out_valid, y}), 64'h130);
    end
    check("bp_accepted", 64'(exp_q.size()), 64'd2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd4, 8'hAA, 8'h55);
    send(3'd6, 8'h5A, 8'h00);
    drain(4);
    cmp_const("bp_b0", 8'h30, 3'b000);
    cmp_const("bp_b1", 8'hFF, 3'b010);
    cmp_const("bp_b2", 8'hFF, 3'b010);
    cmp_const("bp_b3", 8'hA5, 3'b000);
    check("bp_done", 64'(done_count), 64'd4);

    // Full throughput random stream
    for (int i = 0; i < 100; i++) send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    drain(100);
    for (int i = 0; i < 100; i++) cmp_model("thru", 2);

    // Random out_ready toggling
    begin
      bit sent_all = 1'b0;
      fork
        begin
          for (int i = 0; i < 40; i++) send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
          sent_all = 1'b1;
        end
        begin
          for (int i = 0; i < 2000 && !sent_all; i++) begin
            @(posedge clk);
            #1;
            out_ready = 1'($urandom);
          end
        end
      join
    end
    out_ready = 1'b1;
    drain(40);
    for (int i = 0; i < 40; i++) cmp_model("toggle", -1);

    // Reset mid-stream with two beats in flight
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(3'd7, 8'(i), 8'h00);
    drain(3);
    check("mid_done_pre", 64'(done_count), 64'd3);
    out_ready = 1'b0;
    send(3'd7, 8'h11, 8'h00);
    send(3'd7, 8'h22, 8'h00);
    @(negedge clk);
    check("mid_full", 64'({out_valid, y}), 64'h111);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_y", 64'(y), 64'd0);
    check("mid_done", 64'(done_count), 64'd0);
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_no_stale", 64'({obs_q.size() != 0, out_valid}), 64'd0);

    // Counter wrap with CNT_W=4
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(3'd0, 8'hFF, 8'(i));
    drain(17);
    check("wrap_done", 64'(done_count), 64'd1);
    for (int i = 0; i < 17; i++) cmp_model("wrap", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logic_op_pipe.md
# logic_op_pipe

Parametrised, pipelined bitwise logic unit that generalises the two-input NAND primitive.
- Applies one of eight selectable bitwise operations to two WIDTH-bit operands.
- Registers the result through a two-stage valid/ready pipeline with full backpressure.
- Reports zero, all-ones and parity flags on every result.
- Sits between an operand producer and any ready/valid consumer in the datapath library.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (1..64)
- CNT_W, 16, width of completed-transaction counter

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept operand beat
- op  input  3  operation select, sampled with operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  result
- y_zero  output  1  y == 0
- y_ones  output  1  y == all ones
- y_parity  output  1  XOR-reduction of y
- done_count  output  CNT_W  number of results accepted downstream, wraps

## Operation
- Op encoding:
  - 000 AND
  - 001 OR
  - 010 NAND
  - 011 NOR
  - 100 XOR
  - 101 XNOR
  - 110 NOT a (b ignored)
  - 111 PASS a (b ignored)
- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready.
- Stage 1 (S1) registers a, b and op, and sets s1_valid.
- Stage 2 (S2) computes the op from S1 and registers y and the three flags; its valid is out_valid.
- Advance rules:
  - S2 loads when !out_valid || out_ready.
  - S1 loads when !s1_valid || S2 loads.
  - in_ready = !s1_valid || S2 loads. This is combinational from out_ready; no combinational in_valid→out path.
- Bubble handling:
  - If S2 loads while s1_valid = 0, out_valid clears (only when the current beat has transferred or S2 was empty).
  - If S1 loads while no input transfer occurs, s1_valid clears.
- While out_valid && !out_ready: y and flags hold stable, and S1 holds its beat. The pipeline stores at most 2 beats; in_ready deasserts when both stages are full.
- done_count increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.
- Flags are computed from the same combinational result loaded into y, never from registered y.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - out_valid = 0 and s1_valid = 0
  - y = 0, y_zero = 0, y_ones = 0, y_parity = 0
  - done_count = 0
  - in_ready = 1 on the first cycle after release
- Reset mid-operation discards all in-flight beats; no partial result appears after release.
- Latency: an input transfer at edge N gives out_valid = 1 after edge N+1.
- Throughput: 1 beat/cycle with out_ready held high.
- A simultaneous output transfer and input transfer with both stages full is legal and keeps full throughput.
- Per-edge flow when both stages are full:
  - out_ready = 0: in_ready = 0.
  - out_ready = 1: S2 takes S1, S1 takes the new beat, and done_count increments in the same edge.
- WIDTH = 1: y_zero = !y, y_ones = y, y_parity = y.

## Structure
- Package logic_op_pkg holds:
  - op enum/localparams: OP_AND..OP_PASS
  - OP_W = 3
- Sub-module gate_alu is purely combinational: inputs op, a, b; outputs y, zero, ones, parity; parametrised by WIDTH.
- logic_op_pipe holds both pipeline stages, the handshake logic and the counter.

## Test plan
- Ops sweep, WIDTH=8, out_ready=1: a=8'hC3, b=8'hA5 for ops 0..7. Required y, in order: 81, E7, 7E, 18, 66, 99, 3C, C3; each 2 cycles after acceptance.
- Flags: NAND a=b=8'hFF → y=00, y_zero=1, y_parity=0. NOR a=b=00 → y=FF, y_ones=1, y_parity=0. XOR 01/00 → y_parity=1.
- Backpressure: hold out_ready=0 and stream 4 beats. Required:
  - exactly 2 accepted, then in_ready=0
  - y stable across the stall
  - on release, the beats emerge in order with no loss or duplication
  - done_count=4 at the end
- Full throughput: 100 random beats with out_ready=1 continuously → one result per cycle and results match a reference model.
- Random out_ready toggling → results match the scoreboard.
- Reset mid-stream: assert rst_n low asynchronously between edges with 2 beats in flight. Required:
  - out_valid drops immediately and y=0
  - done_count=0
  - no stale beat after release
- Counter wrap with CNT_W=4: 17 output transfers → done_count=1.
